controle_medida_hcsr04: RTL and testbench

Control unit that sequences the ultrasonic interface datapath: zera, gera, wait for echo, registra. Runs in single-shot or periodic mode, with an echo timeout and out-of-range detection. It also produces a validated floor number for the SmartCargo elevator logic, so the elevator FSM sees one clean "new floor" strobe per measurement.

---
 rtl/controle_medida_pkg.sv | 23 ++
 rtl/controle_medida_hcsr04_filtro_andar.sv | 58 +++++
 rtl/controle_medida_hcsr04.sv | 161 ++++++++++++++++
 tb/tb_controle_medida_hcsr04.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_medida_pkg.sv
// Shared definitions for the HC-SR04 measurement controller.
// Contents: FSM state encoding (values double as the estado_db debug code)
//           and default clock-count constants for a 50 MHz core clock.
package controle_medida_pkg;

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    PREPARA   = 4'd1,
    ENVIA     = 4'd2,
    ESPERA    = 4'd3,
    ARMAZENA  = 4'd4,
    FORA      = 4'd5,
    TEMPO     = 4'd6,
    FINAL     = 4'd7,
    INTERVALO = 4'd8
  } estado_t;

  localparam int PERIODO_50MHZ    = 3_000_000;  // 60 ms trigger-to-trigger
  localparam int TIMEOUT_50MHZ    = 1_500_000;  // 30 ms echo window
  localparam int N_ESTAVEL_PADRAO = 3;
  localparam int LARG_CNT_PADRAO  = 22;

endpackage

// File: rtl/controle_medida_hcsr04_filtro_andar.sv
// Floor stability filter: publishes a floor only after N_ESTAVEL equal samples.
// Latency: andar_valido/andar_novo update on the edge ending the sample cycle.
// Backpressure: none; samples are taken whenever amostra is high.
// Ports: clock, reset (async, active-high); amostra = take andar_fd this cycle;
//        limpa = clear the run counter; andar_valido = stable floor;
//        andar_novo = one-cycle strobe when andar_valido changes.
module filtro_andar #(
  parameter int N_ESTAVEL = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       amostra,
  input  logic       limpa,
  input  logic [1:0] andar_fd,
  output logic [1:0] andar_valido,
  output logic       andar_novo
);

  localparam int              LC    = $clog2(N_ESTAVEL + 1);
  localparam logic [LC-1:0]   N_MAX = LC'(N_ESTAVEL);

  logic [LC-1:0] cnt;
  logic [LC-1:0] cnt_prox;
  logic [1:0]    ultima;

  // Run length of equal samples, saturating so a long stable run never wraps
  // back below N_MAX.
  always_comb begin
    cnt_prox = cnt;
    if (andar_fd == ultima) begin
      if (cnt != N_MAX) cnt_prox = cnt + 1'b1;
    end else begin
      cnt_prox = LC'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      ultima       <= '0;
      andar_valido <= '0;
      andar_novo   <= 1'b0;
    end else begin
      andar_novo <= 1'b0;
      if (limpa) begin
        cnt <= '0;
      end else if (amostra) begin
        cnt    <= cnt_prox;
        ultima <= andar_fd;
        if (cnt_prox == N_MAX && andar_fd != andar_valido) begin
          andar_valido <= andar_fd;
          andar_novo   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/controle_medida_hcsr04.sv
// HC-SR04 measurement sequencer: zera -> gera -> wait echo -> registra/abort -> pronto.
// Latency: medir to gera 2 clocks; continuous mode re-triggers every PERIODO clocks.
// Backpressure: none; a started cycle always runs through FINAL before idling.
// Ports: clock, reset (async, active-high); habilita/continuo/medir control;
//        fim_medida/fim/andar_fd from the datapath; zera/gera/registra to the
//        datapath; pronto/erro_timeout/fora_alcance/andar_novo one-cycle strobes;
//        andar_valido last published floor; estado_db state code.
// Macro ANDAR_FILTRO_EN: when defined, floors pass through filtro_andar; when
// undefined, andar_valido follows every stored measurement directly.
module controle_medida_hcsr04
  import controle_medida_pkg::*;
#(
  parameter int PERIODO   = PERIODO_50MHZ,
  parameter int TIMEOUT   = TIMEOUT_50MHZ,
  parameter int N_ESTAVEL = N_ESTAVEL_PADRAO,
  parameter int LARG_CNT  = LARG_CNT_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic       continuo,
  input  logic       medir,
  input  logic       fim_medida,
  input  logic       fim,
  input  logic [1:0] andar_fd,
  output logic       zera,
  output logic       gera,
  output logic       registra,
  output logic       pronto,
  output logic       erro_timeout,
  output logic       fora_alcance,
  output logic [1:0] andar_valido,
  output logic       andar_novo,
  output logic [3:0] estado_db
);

  // Both timers read 0 in the ENVIA cycle and k in the k-th cycle after it.
  // INTERVALO leaves one cycle early so PREPARA+ENVIA land the next gera
  // exactly PERIODO clocks after the previous one.
  localparam logic [LARG_CNT-1:0] LIM_PER = LARG_CNT'(PERIODO - 2);
  localparam logic [LARG_CNT-1:0] LIM_TO  = LARG_CNT'(TIMEOUT - 1);

  // The slowest path (timeout) must reach INTERVALO before the period expires.
  localparam bit PARAMS_OK = (PERIODO >= TIMEOUT + 8) && (N_ESTAVEL >= 1);

  parametros_ok: assert property (@(posedge clock) PARAMS_OK);

  estado_t             estado;
  logic [LARG_CNT-1:0] tmr_per;
  logic [LARG_CNT-1:0] tmr_to;

  assign estado_db = estado;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= OCIOSO;
      zera         <= 1'b0;
      gera         <= 1'b0;
      registra     <= 1'b0;
      pronto       <= 1'b0;
      erro_timeout <= 1'b0;
      fora_alcance <= 1'b0;
      tmr_per      <= '0;
      tmr_to       <= '0;
    end else begin
      zera         <= 1'b0;
      gera         <= 1'b0;
      registra     <= 1'b0;
      pronto       <= 1'b0;
      erro_timeout <= 1'b0;
      fora_alcance <= 1'b0;

      // Period timer runs in every state and is only cleared entering ENVIA.
      if (tmr_per != '1) tmr_per <= tmr_per + 1'b1;

      case (estado)
        OCIOSO: begin
          if (habilita && (continuo || medir)) begin
            estado <= PREPARA;
            zera   <= 1'b1;
          end
        end
        PREPARA: begin
          estado  <= ENVIA;
          gera    <= 1'b1;
          tmr_per <= '0;
          tmr_to  <= '0;
        end
        ENVIA: begin
          estado <= ESPERA;
          if (tmr_to != '1) tmr_to <= tmr_to + 1'b1;
        end
        ESPERA: begin
          if (tmr_to != '1) tmr_to <= tmr_to + 1'b1;
          if (fim) begin
            estado       <= FORA;
            fora_alcance <= 1'b1;
          end else if (fim_medida) begin
            estado   <= ARMAZENA;
            registra <= 1'b1;
          end else if (tmr_to == LIM_TO) begin
            estado       <= TEMPO;
            erro_timeout <= 1'b1;
          end
        end
        ARMAZENA, FORA, TEMPO: begin
          estado <= FINAL;
          pronto <= 1'b1;
        end
        FINAL: begin
          estado <= (continuo && habilita) ? INTERVALO : OCIOSO;
        end
        INTERVALO: begin
          if (!habilita || !continuo) begin
            estado <= OCIOSO;
          end else if (tmr_per == LIM_PER) begin
            estado <= PREPARA;
            zera   <= 1'b1;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

`ifdef ANDAR_FILTRO_EN
  logic amostra;
  logic limpa;

  assign amostra = (estado == ARMAZENA);
  assign limpa   = (estado == FORA) || (estado == TEMPO);

  filtro_andar #(
    .N_ESTAVEL(N_ESTAVEL)
  ) u_filtro (
    .clock       (clock),
    .reset       (reset),
    .amostra     (amostra),
    .limpa       (limpa),
    .andar_fd    (andar_fd),
    .andar_valido(andar_valido),
    .andar_novo  (andar_novo)
  );
`else
  // Unfiltered: every stored measurement is published; aborted cycles keep
  // the previous floor.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      andar_valido <= '0;
      andar_novo   <= 1'b0;
    end else begin
      andar_novo <= 1'b0;
      if (estado == ARMAZENA) begin
        andar_valido <= andar_fd;
        andar_novo   <= (andar_fd != andar_valido);
      end
    end
  end
`endif

endmodule

// File: tb/tb_controle_medida_hcsr04.sv
// Bench for controle_medida_hcsr04 with shortened timing parameters.
// Pulse times are predicted from gera with plain arithmetic; floors come from
// a run-length model of the stability rule (or direct follow when unfiltered).
module tb_controle_medida_hcsr04;

  localparam int PERIODO   = 400;
  localparam int TIMEOUT   = 200;
  localparam int N_ESTAVEL = 3;
  localparam int LARG_CNT  = 12;

  // Measurement outcomes driven by the bench.
  localparam int T_OK      = 0;  // fim_medida only
  localparam int T_FIM     = 1;  // fim only
  localparam int T_AMBOS   = 2;  // fim and fim_medida together
  localparam int T_TIMEOUT = 3;  // no echo

`ifdef ANDAR_FILTRO_EN
  localparam int MASK_SEQ = 6'b100000;
`else
  localparam int MASK_SEQ = 6'b001101;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       habilita = 1'b0;
  logic       continuo = 1'b0;
  logic       medir = 1'b0;
  logic       fim_medida = 1'b0;
  logic       fim = 1'b0;
  logic [1:0] andar_fd = 2'd0;
  logic       zera, gera, registra, pronto, erro_timeout, fora_alcance, andar_novo;
  logic [1:0] andar_valido;
  logic [3:0] estado_db;

  controle_medida_hcsr04 #(
    .PERIODO  (PERIODO),
    .TIMEOUT  (TIMEOUT),
    .N_ESTAVEL(N_ESTAVEL),
    .LARG_CNT (LARG_CNT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .habilita    (habilita),
    .continuo    (continuo),
    .medir       (medir),
    .fim_medida  (fim_medida),
    .fim         (fim),
    .andar_fd    (andar_fd),
    .zera        (zera),
    .gera        (gera),
    .registra    (registra),
    .pronto      (pronto),
    .erro_timeout(erro_timeout),
    .fora_alcance(fora_alcance),
    .andar_valido(andar_valido),
    .andar_novo  (andar_novo),
    .estado_db   (estado_db)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Cycle stamps of every strobe, sampled mid-cycle.
  int q_zera[$], q_gera[$], q_reg[$], q_pronto[$], q_erro[$], q_fora[$], q_novo[$];

  always @(negedge clock) begin
    if (zera)         q_zera.push_back(cyc);
    if (gera)         q_gera.push_back(cyc);
    if (registra)     q_reg.push_back(cyc);
    if (pronto)       q_pronto.push_back(cyc);
    if (erro_timeout) q_erro.push_back(cyc);
    if (fora_alcance) q_fora.push_back(cyc);
    if (andar_novo)   q_novo.push_back(cyc);
  end

  // Reference floor model.
  logic [1:0] m_valido = 2'd0;
  logic [1:0] m_last = 2'd0;
  int         m_run = 0;

  task automatic verifica(input string tag, input int obs, input int esp);
    checks++;
    if (obs != esp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, esp);
    end
  endtask

  task automatic tic();
    @(negedge clock);
    #1;
  endtask

  function automatic int evento(input int q[$]);
    if (q.size() == 0) return -1;
    if (q.size() > 1) return -2;
    return q[0];
  endfunction

  task automatic limpa_filas();
    q_zera.delete(); q_gera.delete(); q_reg.delete(); q_pronto.delete();
    q_erro.delete(); q_fora.delete(); q_novo.delete();
  endtask

  task automatic modelo_reset();
    m_valido = 2'd0;
    m_last   = 2'd0;
    m_run    = 0;
  endtask

  task automatic modelo_amostra(input logic [1:0] a, output bit novo);
    novo = 1'b0;
`ifdef ANDAR_FILTRO_EN
    if (m_run > 0 && a == m_last) m_run++;
    else m_run = 1;
    m_last = a;
    if (m_run >= N_ESTAVEL && a != m_valido) begin
      m_valido = a;
      novo = 1'b1;
    end
`else
    novo = (a != m_valido);
    m_valido = a;
`endif
  endtask

  task automatic modelo_limpa();
`ifdef ANDAR_FILTRO_EN
    m_run = 0;
`endif
  endtask

  task automatic espera_gera(input int alvo, input int limite);
    int n = 0;
    while (q_gera.size() < alvo && n < limite) begin tic(); n++; end
  endtask

  task automatic espera_pronto(input int alvo, input int limite);
    int n = 0;
    while (q_pronto.size() < alvo && n < limite) begin tic(); n++; end
  endtask

  // One single-shot measurement with the given outcome, fully checked.
  task automatic medida(input int tipo, input int atraso, input logic [1:0] andar,
                        output bit viu_novo);
    int t0, g, t_evt;
    bit novo_esp;
    viu_novo = 1'b0;
    limpa_filas();
    andar_fd = andar;
    medir = 1'b1;
    t0 = cyc;
    espera_gera(1, 10);
    medir = 1'b0;
    verifica("gera_latencia", q_gera.size() > 0 ? q_gera[0] - t0 : -1, 2);
    if (q_gera.size() == 0) return;
    g = q_gera[0];
    verifica("zera", evento(q_zera), g - 1);
    if (tipo != T_TIMEOUT) begin
      while (cyc < g + atraso) tic();
      fim_medida = (tipo != T_FIM);
      fim        = (tipo != T_OK);
      tic();
      fim_medida = 1'b0;
      fim        = 1'b0;
    end
    t_evt = (tipo == T_TIMEOUT) ? g + TIMEOUT : g + atraso + 1;
    espera_pronto(1, TIMEOUT + 20);
    tic(); tic();
    verifica("pronto", evento(q_pronto), t_evt + 1);
    verifica("registra", evento(q_reg), tipo == T_OK ? t_evt : -1);
    verifica("fora_alcance", evento(q_fora), (tipo == T_FIM || tipo == T_AMBOS) ? t_evt : -1);
    verifica("erro_timeout", evento(q_erro), tipo == T_TIMEOUT ? t_evt : -1);
    if (tipo == T_OK) modelo_amostra(andar, novo_esp);
    else begin modelo_limpa(); novo_esp = 1'b0; end
    verifica("andar_novo", evento(q_novo), novo_esp ? t_evt + 1 : -1);
    verifica("andar_valido", andar_valido, m_valido);
    verifica("gera_unico", q_gera.size(), 1);
    verifica("estado_ocioso", estado_db, 0);
    viu_novo = (q_novo.size() > 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit         vn;
    int         mask;
    int         g;
    int         r;
    logic [1:0] seq [6];
    seq = '{2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2};

    // Reset state
    tic(); tic();
    verifica("rst_estado", estado_db, 0);
    verifica("rst_saidas", {zera, gera, registra, pronto, erro_timeout, fora_alcance, andar_novo}, 0);
    verifica("rst_andar", andar_valido, 0);
    reset = 1'b0;
    habilita = 1'b1;
    modelo_reset();
    tic();

    // Floor sequence; the first one doubles as the basic single-shot check.
    mask = 0;
    for (int i = 0; i < 6; i++) begin
      medida(T_OK, (i == 0) ? 100 : 20 + 7 * i, seq[i], vn);
      mask |= int'(vn) << i;
      tic();
    end
    verifica("seq_novo_mascara", mask, MASK_SEQ);
    verifica("seq_valido", andar_valido, 2);

    // Boundaries: echo on the last legal cycle, overflow coinciding with echo,
    // plain timeout.
    medida(T_OK, TIMEOUT - 1, 2'd3, vn);
    medida(T_AMBOS, 40, 2'd0, vn);
    medida(T_TIMEOUT, 0, 2'd1, vn);
    verifica("timeout_mantem", andar_valido, m_valido);

    // Randomized single-shot traffic.
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 5);
      medida(r <= 2 ? T_OK : r - 2, $urandom_range(1, TIMEOUT - 1),
             2'($urandom_range(0, 3)), vn);
      tic();
    end

    // Continuous mode: four triggers, exact spacing.
    limpa_filas();
    andar_fd = 2'($urandom_range(0, 3));
    continuo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      espera_gera(i + 1, PERIODO + 20);
      if (q_gera.size() < i + 1) break;
      g = q_gera[i];
      while (cyc < g + 50) tic();
      fim_medida = 1'b1;
      tic();
      fim_medida = 1'b0;
      modelo_amostra(andar_fd, vn);
    end
    verifica("cont_n_gera", q_gera.size(), 4);
    for (int i = 1; i < q_gera.size(); i++)
      verifica("cont_periodo", q_gera[i] - q_gera[i-1], PERIODO);
    espera_pronto(4, 100);
    repeat (10) tic();
    verifica("cont_registra", q_reg.size(), 4);
    verifica("cont_intervalo", estado_db, 8);
    verifica("cont_andar", andar_valido, m_valido);
    continuo = 1'b0;
    tic();
    verifica("cont_para", estado_db, 0);

    // habilita dropped mid-measurement: cycle completes, then idle.
    limpa_filas();
    continuo = 1'b1;
    andar_fd = 2'($urandom_range(0, 3));
    espera_gera(1, 10);
    g = (q_gera.size() > 0) ? q_gera[0] : cyc;
    while (cyc < g + 5) tic();
    habilita = 1'b0;
    while (cyc < g + 20) tic();
    fim_medida = 1'b1;
    tic();
    fim_medida = 1'b0;
    modelo_amostra(andar_fd, vn);
    espera_pronto(1, 50);
    repeat (30) tic();
    verifica("hab_pronto", evento(q_pronto), g + 22);
    verifica("hab_registra", evento(q_reg), g + 21);
    verifica("hab_ocioso", estado_db, 0);
    verifica("hab_sem_novo_gera", q_gera.size(), 1);
    verifica("hab_andar", andar_valido, m_valido);
    continuo = 1'b0;
    medir = 1'b1;
    repeat (10) tic();
    verifica("hab_bloqueia", q_gera.size(), 1);
    medir = 1'b0;
    habilita = 1'b1;
    tic();

    // Async reset in ESPERA after publishing a nonzero floor.
    for (int i = 0; i < N_ESTAVEL; i++) medida(T_OK, 30, 2'd3, vn);
    verifica("pre_rst_andar", andar_valido, 3);
    limpa_filas();
    medir = 1'b1;
    espera_gera(1, 10);
    medir = 1'b0;
    repeat (10) tic();
    verifica("pre_rst_espera", estado_db, 3);
    reset = 1'b1;
    #1;
    verifica("arst_estado", estado_db, 0);
    verifica("arst_andar", andar_valido, 0);
    verifica("arst_saidas", {zera, gera, registra, pronto, erro_timeout, fora_alcance, andar_novo}, 0);
    tic(); tic();
    reset = 1'b0;
    modelo_reset();
    tic();
    medida(T_OK, 60, 2'($urandom_range(0, 3)), vn);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
